// File: rtl/csc_col_buf_pkg.sv
// csc_pkg: shared types and helpers for the compressed-sparse-column store.
//   csc_state_e : controller states (LOAD, READY, FETCH0, FETCH1, STREAM)
//   ridx_w      : row/column index width for a given matrix rank
//   nidx_w      : non-zero address width for a given store depth
//   ch_lsb      : LSB position of complex channel k in a packed channel bus
package csc_pkg;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_READY,
    ST_FETCH0,
    ST_FETCH1,
    ST_STREAM
  } csc_state_e;

  function automatic int unsigned ridx_w(input int unsigned mat_rank);
    return $clog2(mat_rank);
  endfunction

  function automatic int unsigned nidx_w(input int unsigned nnz_depth);
    return $clog2(nnz_depth);
  endfunction

  // Channel k of a packed bus occupies [k*data_w +: data_w].
  function automatic int unsigned ch_lsb(input int unsigned k, input int unsigned data_w);
    return k * data_w;
  endfunction

endpackage

// File: rtl/csc_dpram.sv
// csc_dpram: simple dual-port RAM, one write port and one synchronous read port.
//   clk      : clock
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_raddr  : read address, sampled every cycle
//   o_rdata  : read data, one cycle after i_raddr
// Contents are never reset.
module csc_dpram #(
  parameter int unsigned W  = 8,
  parameter int unsigned D  = 16,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [D];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/csc_col_buf.sv
// csc_col_buf: CSC store for complex matrices with NUM_CH value channels per
// non-zero. A column-major load stream fills value, row-index and column-end
// memories; afterwards any column can be replayed as a valid/ready stream.
//   clk, rst_n (async, active low), clr (sync clear back to LOAD)
//   wr_*      : load stream (wr_nz=0 is a bookkeeping beat; wr_col_last closes a column)
//   mat_ready : all columns loaded;  nnz_cnt : stored non-zeros;  ovf : sticky store-full drop
//   rd_req/rd_col/rd_busy : column request interface
//   out_*     : column replay stream; out_empty marks a column with no non-zeros
//   err_row   : sticky row-order/range error
// Optional feature macro CSC_COL_BUF_ROW_CHK_EN: drop non-zeros whose row is out of
// range or not strictly increasing within the column; otherwise err_row is 0.
module csc_col_buf
  import csc_pkg::*;
#(
  parameter  int unsigned MAT_RANK  = 256,
  parameter  int unsigned DATA_W    = 32,
  parameter  int unsigned NUM_CH    = 3,
  parameter  int unsigned NNZ_DEPTH = 1024,
  localparam int unsigned RIDX_W    = ridx_w(MAT_RANK),
  localparam int unsigned NIDX_W    = nidx_w(NNZ_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     wr_vld,
  output logic                     wr_rdy,
  input  logic                     wr_nz,
  input  logic [RIDX_W-1:0]        wr_row,
  input  logic [NUM_CH*DATA_W-1:0] wr_re,
  input  logic [NUM_CH*DATA_W-1:0] wr_im,
  input  logic                     wr_col_last,
  output logic                     mat_ready,
  output logic [NIDX_W:0]          nnz_cnt,
  output logic                     ovf,
  input  logic                     rd_req,
  input  logic [RIDX_W-1:0]        rd_col,
  output logic                     rd_busy,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [RIDX_W-1:0]        out_row,
  output logic [NUM_CH*DATA_W-1:0] out_re,
  output logic [NUM_CH*DATA_W-1:0] out_im,
  output logic                     out_last,
  output logic                     out_empty,
  output logic                     err_row
);

  localparam int unsigned CW = NUM_CH * DATA_W;
  localparam int unsigned VW = 2 * CW;
  localparam logic [RIDX_W:0] RANK_V  = (RIDX_W+1)'(MAT_RANK);
  localparam logic [NIDX_W:0] DEPTH_V = (NIDX_W+1)'(NNZ_DEPTH);

  csc_state_e        r_state;
  logic              r_wr_rdy, r_mat_ready, r_busy, r_ovf;
  logic [NIDX_W:0]   r_nnz;
  logic [RIDX_W:0]   r_col;
  logic [RIDX_W-1:0] r_rcol;
  logic [NIDX_W:0]   r_ptr, r_end;
  logic              r_first, r_pend, r_pend_last;
  logic [RIDX_W-1:0] r_f_row [2];
  logic [VW-1:0]     r_f_val [2];
  logic [1:0]        r_f_last, r_f_empty;
  logic              r_wp, r_rp;
  logic [1:0]        r_cnt;

  logic              w_hs, w_nz_hs, w_full, w_row_ok, w_acc;
  logic [NIDX_W:0]   w_nnz_nxt, w_ce_q, w_end;
  logic [RIDX_W-1:0] w_ce_raddr, w_row_q;
  logic [VW-1:0]     w_val_q;
  logic              w_pop, w_push, w_push_empty, w_issue;
  logic [2:0]        w_occ;

  // clr wins over a simultaneous load beat
  assign w_hs      = wr_vld & r_wr_rdy & ~clr;
  assign w_nz_hs   = w_hs & wr_nz;
  assign w_full    = (r_nnz == DEPTH_V);
  assign w_acc     = w_nz_hs & ~w_full & w_row_ok;
  assign w_nnz_nxt = r_nnz + (NIDX_W+1)'(w_acc);

`ifdef CSC_COL_BUF_ROW_CHK_EN
  logic [RIDX_W-1:0] r_prev_row;
  logic              r_prev_vld, r_err_row;

  assign w_row_ok = ({1'b0, wr_row} < RANK_V) && (!r_prev_vld || (wr_row > r_prev_row));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_row <= '0;
      r_prev_vld <= 1'b0;
      r_err_row  <= 1'b0;
    end else if (clr) begin
      r_prev_vld <= 1'b0;
      r_err_row  <= 1'b0;
    end else begin
      if (w_nz_hs && !w_row_ok) r_err_row <= 1'b1;
      if (w_acc) begin
        r_prev_row <= wr_row;
        r_prev_vld <= 1'b1;
      end
      if (w_hs && wr_col_last) r_prev_vld <= 1'b0;
    end
  end
  assign err_row = r_err_row;
`else
  assign w_row_ok = 1'b1;
  assign err_row  = 1'b0;
`endif

  csc_dpram #(.W(VW), .D(NNZ_DEPTH), .AW(NIDX_W)) u_val (
    .clk(clk), .i_we(w_acc), .i_waddr(r_nnz[NIDX_W-1:0]), .i_wdata({wr_re, wr_im}),
    .i_raddr(r_ptr[NIDX_W-1:0]), .o_rdata(w_val_q));

  csc_dpram #(.W(RIDX_W), .D(NNZ_DEPTH), .AW(NIDX_W)) u_row (
    .clk(clk), .i_we(w_acc), .i_waddr(r_nnz[NIDX_W-1:0]), .i_wdata(wr_row),
    .i_raddr(r_ptr[NIDX_W-1:0]), .o_rdata(w_row_q));

  csc_dpram #(.W(NIDX_W+1), .D(MAT_RANK), .AW(RIDX_W)) u_colend (
    .clk(clk), .i_we(w_hs & wr_col_last), .i_waddr(r_col[RIDX_W-1:0]), .i_wdata(w_nnz_nxt),
    .i_raddr(w_ce_raddr), .o_rdata(w_ce_q));

  // FETCH0 addresses colend[c-1] (start), FETCH1 colend[c] (end); the end value
  // arrives on the RAM output during the first STREAM cycle.
  assign w_ce_raddr = (r_state == ST_FETCH0) ? (r_rcol - RIDX_W'(1)) : r_rcol;
  assign w_end      = r_first ? w_ce_q : r_end;

  assign out_vld = (r_cnt != 2'd0);
  assign w_pop   = out_vld & out_rdy;

  // Occupancy counts in-flight reads and credits a pop this cycle, so a read
  // issues every cycle while the consumer keeps up.
  always_comb begin
    w_occ = 3'(r_cnt) + 3'(r_pend) - 3'(w_pop);
  end
  assign w_issue      = (r_state == ST_STREAM) && (r_ptr < w_end) && (w_occ < 3'd2);
  assign w_push_empty = (r_state == ST_STREAM) && r_first && (r_ptr == w_end);
  assign w_push       = r_pend | w_push_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_LOAD;
      r_wr_rdy    <= 1'b1;
      r_mat_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_ovf       <= 1'b0;
      r_nnz       <= '0;
      r_col       <= '0;
      r_rcol      <= '0;
    end else if (clr) begin
      r_state     <= ST_LOAD;
      r_wr_rdy    <= 1'b1;
      r_mat_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_ovf       <= 1'b0;
      r_nnz       <= '0;
      r_col       <= '0;
    end else begin
      if (w_nz_hs && w_full) r_ovf <= 1'b1;
      r_nnz <= w_nnz_nxt;
      unique case (r_state)
        ST_LOAD: begin
          if (w_hs && wr_col_last) begin
            r_col <= r_col + (RIDX_W+1)'(1);
            if (r_col + (RIDX_W+1)'(1) == RANK_V) begin
              r_state     <= ST_READY;
              r_wr_rdy    <= 1'b0;
              r_mat_ready <= 1'b1;
            end
          end
        end
        ST_READY: begin
          if (rd_req && ({1'b0, rd_col} < RANK_V)) begin
            r_rcol  <= rd_col;
            r_state <= ST_FETCH0;
            r_busy  <= 1'b1;
          end
        end
        ST_FETCH0: r_state <= ST_FETCH1;
        ST_FETCH1: r_state <= ST_STREAM;
        ST_STREAM: begin
          if (w_pop && out_last) begin
            r_state <= ST_READY;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_end       <= '0;
      r_first     <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_last <= 1'b0;
      r_f_row     <= '{default: '0};
      r_f_val     <= '{default: '0};
      r_f_last    <= '0;
      r_f_empty   <= '0;
      r_wp        <= 1'b0;
      r_rp        <= 1'b0;
      r_cnt       <= '0;
    end else if (clr) begin
      r_first <= 1'b0;
      r_pend  <= 1'b0;
      r_wp    <= 1'b0;
      r_rp    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (r_state == ST_FETCH1) begin
        r_ptr   <= (r_rcol == '0) ? '0 : w_ce_q;
        r_first <= 1'b1;
      end else if (w_issue) begin
        r_ptr <= r_ptr + (NIDX_W+1)'(1);
      end
      if (r_first) begin
        r_first <= 1'b0;
        r_end   <= w_ce_q;
      end
      r_pend      <= w_issue;
      r_pend_last <= (r_ptr + (NIDX_W+1)'(1) == w_end);
      if (w_push) begin
        r_f_row[r_wp]   <= r_pend ? w_row_q : '0;
        r_f_val[r_wp]   <= r_pend ? w_val_q : '0;
        r_f_last[r_wp]  <= r_pend ? r_pend_last : 1'b1;
        r_f_empty[r_wp] <= ~r_pend;
        r_wp            <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
    end
  end

  assign out_row   = out_vld ? r_f_row[r_rp] : '0;
  assign out_re    = out_vld ? r_f_val[r_rp][VW-1:CW] : '0;
  assign out_im    = out_vld ? r_f_val[r_rp][CW-1:0] : '0;
  assign out_last  = out_vld & r_f_last[r_rp];
  assign out_empty = out_vld & r_f_empty[r_rp];

  assign wr_rdy    = r_wr_rdy;
  assign mat_ready = r_mat_ready;
  assign nnz_cnt   = r_nnz;
  assign ovf       = r_ovf;
  assign rd_busy   = r_busy;

endmodule
